fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Purpose: instruction fetch sequencer (IDLE -> FETCH -> ISSUE) that reads code
//          memory at pc_addr, holds the word in ir and waits for the control unit.
// Latency: ir_valid 2 cycles after run/step sampled in IDLE; 2 cycles after ex_done when running.
// Backpressure: ISSUE holds ir/pc_addr stable until ex_done; run=0 parks the unit in IDLE.
//
// Ports:
//   clock, reset         rising-edge clock; asynchronous active-high reset
//   run, step            free-run level / single-instruction pulse (step honoured only in IDLE with run=0)
//   instr_in             code memory read data for the address on pc_addr
//   ex_done              completion pulse for the issued instruction (ignored outside ISSUE)
//   branch_taken/offset  next-PC selection, qualified by ex_done
//   pc_addr, ir          current PC and instruction register
//   ir_valid, busy       ir holds an issued instruction / unit not IDLE
//   instr_count          saturating count of completed instructions
module fetch_unit #(
   parameter logic [5:0] PC_RESET = 6'd32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        run,
   input  logic        step,
   input  logic [15:0] instr_in,
   input  logic        ex_done,
   input  logic        branch_taken,
   input  logic [5:0]  branch_offset,
   output logic [5:0]  pc_addr,
   output logic [15:0] ir,
   output logic        ir_valid,
   output logic        busy,
   output logic [15:0] instr_count
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] ISSUE = 2'd2;

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic       step_pending;
   logic       accept_done;
   logic [5:0] pc_next;

   // Only a completion seen while an instruction is actually issued counts.
   assign accept_done = (state == ISSUE) && ex_done;

   // A 6-bit add of the two's-complement offset is the same as adding its
   // sign extension and reducing modulo 64, so wrap in both directions is free.
   always_comb begin
      pc_next = pc_addr + 6'd1;
      if (branch_taken) begin
         pc_next = pc_addr + 6'd1 + branch_offset;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (run || step || step_pending) begin
               state_nxt = FETCH;
            end
         end
         FETCH: begin
            state_nxt = ISSUE;
         end
         ISSUE: begin
            // A falling run never aborts the issued instruction; it only
            // decides where we go once ex_done arrives.
            if (ex_done) begin
               state_nxt = run ? FETCH : IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         pc_addr      <= PC_RESET;
         ir           <= 16'h0000;
         instr_count  <= 16'h0000;
         step_pending <= 1'b0;
      end else begin
         state <= state_nxt;

         if (state == FETCH) begin
            ir <= instr_in;
         end

         if (accept_done) begin
            pc_addr <= pc_next;
            if (instr_count != 16'hFFFF) begin
               instr_count <= instr_count + 16'd1;
            end
         end

         // Steps are only latched from IDLE with run low; any step seen while
         // busy or free-running is dropped.
         if (accept_done) begin
            step_pending <= 1'b0;
         end else if ((state == IDLE) && step && !run) begin
            step_pending <= 1'b1;
         end
      end
   end

   assign ir_valid = (state == ISSUE);
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_fetch_unit.sv
// Purpose: randomized scoreboard bench for fetch_unit against a PC/count reference model.
// Latency: expects each issue exactly 2 cycles after the launching run/step or ex_done.
// Backpressure: drives ex_done only after ir_valid is observed, with random hold-off.
module tb_fetch_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        run = 1'b0;
   logic        step = 1'b0;
   logic        ex_done = 1'b0;
   logic        branch_taken = 1'b0;
   logic [5:0]  branch_offset = 6'd0;
   logic [15:0] instr_in;
   logic [5:0]  pc_addr;
   logic [15:0] ir;
   logic        ir_valid;
   logic        busy;
   logic [15:0] instr_count;

   logic [15:0] mem [64];

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {
      int pc;
      int ir;
      int cnt;
      int cyc;
   } item_t;

   item_t exp_q[$];
   item_t cur;
   bit    prev_v = 1'b0;

   // Reference model: architectural PC, completed count, whether the unit is parked.
   int m_pc;
   int m_cnt;
   int m_last_ir;
   bit idle;

   fetch_unit #(.PC_RESET(6'd32)) dut (
      .clock        (clock),
      .reset        (reset),
      .run          (run),
      .step         (step),
      .instr_in     (instr_in),
      .ex_done      (ex_done),
      .branch_taken (branch_taken),
      .branch_offset(branch_offset),
      .pc_addr      (pc_addr),
      .ir           (ir),
      .ir_valid     (ir_valid),
      .busy         (busy),
      .instr_count  (instr_count)
   );

   assign instr_in = mem[pc_addr];

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic push_exp();
      item_t it;
      it.pc  = m_pc;
      it.ir  = int'(mem[m_pc]);
      it.cnt = m_cnt;
      it.cyc = cyc + 2;
      exp_q.push_back(it);
   endtask

   // Monitor: each new ISSUE must match the oldest expected issue; while in
   // ISSUE the ir and pc_addr must not move.
   always @(negedge clock) begin
      if (reset) begin
         prev_v = 1'b0;
      end else begin
         if (ir_valid && !prev_v) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_issue: ir_valid=1 at pc_addr=%0d, required no issue", pc_addr);
            end else begin
               cur = exp_q.pop_front();
               chk("issue_pc", int'(pc_addr), cur.pc);
               chk("issue_ir", int'(ir), cur.ir);
               chk("issue_count", int'(instr_count), cur.cnt);
               chk("issue_cycle", cyc, cur.cyc);
               chk("issue_busy", int'(busy), 1);
            end
         end else if (ir_valid) begin
            chk("hold_pc", int'(pc_addr), cur.pc);
            chk("hold_ir", int'(ir), cur.ir);
         end
         prev_v = ir_valid;
      end
   end

   task automatic wait_issue();
      int n = 0;
      while (!ir_valid && n < 8) begin
         @(negedge clock);
         n++;
      end
      if (!ir_valid) begin
         checks++;
         failures++;
         $display("FAIL issue_timeout: ir_valid=%0d after %0d cycles, required 1", ir_valid, n);
      end
   endtask

   task automatic launch(input bit use_step);
      if (use_step) step = 1'b1;
      else          run  = 1'b1;
      push_exp();
      idle = 1'b0;
      @(negedge clock);
      step = 1'b0;
   endtask

   // Called at a negedge with the unit in ISSUE.
   task automatic finish_instr(input bit br, input logic [5:0] off, input int dly,
                               input bit spur, input bit new_run, input bit wide);
      int t;
      run = new_run;
      for (int i = 0; i < dly; i++) begin
         step = spur && (i == 0);
         @(negedge clock);
         step = 1'b0;
      end
      ex_done       = 1'b1;
      branch_taken  = br;
      branch_offset = off;
      t = m_pc + 1 + (br ? int'($signed(off)) : 0);
      m_last_ir = int'(mem[m_pc]);
      m_pc = ((t % 64) + 64) % 64;
      if (m_cnt < 65535) m_cnt++;
      idle = !new_run;
      if (new_run) push_exp();
      @(negedge clock);
      if (wide) @(negedge clock);
      ex_done      = 1'b0;
      branch_taken = 1'b0;
      if (!new_run) begin
         chk("stop_busy", int'(busy), 0);
         chk("stop_valid", int'(ir_valid), 0);
         chk("stop_ir_kept", int'(ir), m_last_ir);
         chk("stop_count", int'(instr_count), m_cnt);
         chk("stop_pc", int'(pc_addr), m_pc);
      end
   endtask

   task automatic goto_pc(input int target);
      finish_instr(1'b1, 6'(target - m_pc - 1), 1, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic idle_ex_done();
      ex_done       = 1'b1;
      branch_taken  = 1'b1;
      branch_offset = 6'($urandom_range(63));
      @(negedge clock);
      ex_done      = 1'b0;
      branch_taken = 1'b0;
      chk("idle_exdone_pc", int'(pc_addr), m_pc);
      chk("idle_exdone_count", int'(instr_count), m_cnt);
      chk("idle_exdone_busy", int'(busy), 0);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
      mem[32] = 16'hA123;
      m_pc = 32;
      m_cnt = 0;
      m_last_ir = 0;
      idle = 1'b1;

      reset = 1'b1;
      @(negedge clock);
      chk("reset_pc", int'(pc_addr), 32);
      chk("reset_ir", int'(ir), 0);
      chk("reset_valid", int'(ir_valid), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_count", int'(instr_count), 0);
      @(negedge clock);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      chk("no_spontaneous_fetch", int'(busy), 0);

      // First instruction from the reset PC, completion 3 cycles after issue.
      launch(1'b0);
      wait_issue();
      chk("first_ir", int'(ir), 16'hA123);
      finish_instr(1'b0, 6'd0, 3, 1'b0, 1'b1, 1'b0);
      wait_issue();
      chk("second_pc", int'(pc_addr), 33);
      chk("second_count", int'(instr_count), 1);

      // Backward branch from 40, then wrap cases at 63 and 0.
      goto_pc(40);
      wait_issue();
      chk("at_pc40", int'(pc_addr), 40);
      finish_instr(1'b1, 6'b111100, 1, 1'b0, 1'b1, 1'b0);
      wait_issue();
      chk("branch_m4_pc", int'(pc_addr), 37);
      goto_pc(63);
      wait_issue();
      chk("at_pc63", int'(pc_addr), 63);
      finish_instr(1'b0, 6'd0, 0, 1'b0, 1'b1, 1'b0);
      wait_issue();
      chk("wrap_up_pc", int'(pc_addr), 0);
      finish_instr(1'b1, 6'b111101, 2, 1'b0, 1'b1, 1'b0);
      wait_issue();
      chk("wrap_down_pc", int'(pc_addr), 62);

      // run drops during ISSUE, then single-step with a second step mid-ISSUE.
      finish_instr(1'b0, 6'd0, 2, 1'b0, 1'b0, 1'b0);
      chk("run_drop_pc", int'(pc_addr), 63);
      idle_ex_done();
      launch(1'b1);
      wait_issue();
      finish_instr(1'b0, 6'd0, 1, 1'b1, 1'b0, 1'b1);
      chk("step_pc", int'(pc_addr), 0);
      repeat (3) @(negedge clock);
      chk("step_single_issue", int'(busy), 0);

      // Randomized mix of run/step, branches, hold-off and spurious pulses.
      for (int n = 0; n < 250; n++) begin
         if (idle) begin
            if ($urandom_range(2) == 0) idle_ex_done();
            launch(1'($urandom_range(1)));
            wait_issue();
         end
         finish_instr(1'($urandom_range(1)), 6'($urandom_range(63)), int'($urandom_range(4)),
                      1'($urandom_range(1)), ($urandom_range(9) < 7), 1'($urandom_range(1)));
         if (!idle) wait_issue();
      end

      // Asynchronous reset in the middle of an issued instruction.
      if (idle) begin
         launch(1'b0);
         wait_issue();
      end
      #2;
      reset = 1'b1;
      exp_q.delete();
      m_pc = 32;
      m_cnt = 0;
      idle = 1'b1;
      run = 1'b0;
      ex_done = 1'b1;
      #1;
      chk("areset_pc", int'(pc_addr), 32);
      chk("areset_ir", int'(ir), 0);
      chk("areset_valid", int'(ir_valid), 0);
      chk("areset_busy", int'(busy), 0);
      chk("areset_count", int'(instr_count), 0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      ex_done = 1'b0;
      chk("post_reset_pc", int'(pc_addr), 32);
      chk("post_reset_count", int'(instr_count), 0);
      chk("post_reset_busy", int'(busy), 0);
      launch(1'b0);
      wait_issue();
      finish_instr(1'b0, 6'd0, 1, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge clock);
      chk("queue_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
